// File: rtl/frame_sequencer.sv
// Frame sequencer: strips headers from the received byte stream and
// forwards tagged key/data payload bytes to the stream-cipher router.
module frame_sequencer #(
  parameter int KEY_BYTES      = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [7:0] rx_byte,
  input  logic       rx_pulse,
  input  logic       clr_err,
  output logic [7:0] fwd_byte,
  output logic       fwd_is_key,
  output logic       fwd_pulse,
  output logic       key_valid,
  output logic       busy,
  output logic       frame_done,
  output logic       err,
  output logic [1:0] err_code
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_KEY  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [6:0] KLEN = 7'(KEY_BYTES);

  logic [1:0]    state;
  logic [6:0]    rem;
  logic [TW-1:0] tcnt;

  logic [6:0] hdr_len;
  logic       is_key;
  logic       is_data;
  logic       key_ok;
  logic       key_bad;
  logic       data_ok;
  logic       data_bad;
  logic       last;

  assign hdr_len  = {1'b0, rx_byte[5:0]} + 7'd1;
  assign is_key   = (rx_byte[7:6] == 2'b10);
  assign is_data  = (rx_byte[7:6] == 2'b01);
  assign key_ok   = is_key && (hdr_len == KLEN);
  assign key_bad  = is_key && (hdr_len != KLEN);
  assign data_ok  = is_data && key_valid;
  assign data_bad = is_data && !key_valid;
  assign last     = (rem == 7'd1);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= S_IDLE;
      rem        <= '0;
      tcnt       <= '0;
      fwd_byte   <= '0;
      fwd_is_key <= 1'b0;
      fwd_pulse  <= 1'b0;
      key_valid  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;
      err_code   <= 2'b00;
    end else begin
      fwd_byte   <= '0;
      fwd_is_key <= 1'b0;
      fwd_pulse  <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rx_pulse) begin
            unique case (1'b1)
              key_ok: begin
                state     <= S_KEY;
                rem       <= hdr_len;
                tcnt      <= '0;
                key_valid <= 1'b0;
                busy      <= 1'b1;
              end
              data_ok: begin
                state <= S_DATA;
                rem   <= hdr_len;
                tcnt  <= '0;
                busy  <= 1'b1;
              end
              key_bad, data_bad: begin
                state    <= S_ERR;
                err      <= 1'b1;
                err_code <= 2'b10;
              end
              default: begin
                state    <= S_ERR;
                err      <= 1'b1;
                err_code <= 2'b01;
              end
            endcase
          end
        end
        S_KEY, S_DATA: begin
          if (rx_pulse) begin
            fwd_byte   <= rx_byte;
            fwd_is_key <= (state == S_KEY);
            fwd_pulse  <= 1'b1;
            rem        <= rem - 7'd1;
            tcnt       <= '0;
            if (last) begin
              frame_done <= 1'b1;
              state      <= S_IDLE;
              busy       <= 1'b0;
              if (state == S_KEY) key_valid <= 1'b1;
            end
          end else if (tcnt == TMAX) begin
            // key_valid is already low inside a key frame
            state    <= S_ERR;
            busy     <= 1'b0;
            err      <= 1'b1;
            err_code <= 2'b11;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_ERR: begin
          if (clr_err) begin
            state    <= S_IDLE;
            err      <= 1'b0;
            err_code <= 2'b00;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
